// File: rtl/arb_fifo_bridge.sv
// Buffers arbiter words toward the downstream FIFO, counts dropped words and
// inserts one marker word at the position of the first drop after any loss.
module arb_fifo_bridge #(
  parameter int unsigned DEPTH     = 16,
  parameter logic [3:0]  MARKER_ID = 4'hE
) (
  input  logic                   BUS_CLK,
  input  logic                   BUS_RST,
  input  logic                   IN_WRITE,
  input  logic [31:0]            IN_DATA,
  output logic                   IN_READY,
  input  logic                   OUT_FULL,
  output logic                   OUT_WRITE,
  output logic [31:0]            OUT_DATA,
  input  logic                   ENABLE_MARKER,
  input  logic                   CLEAR_CNT,
  output logic [15:0]            LOST_COUNT,
  output logic [31:0]            WORD_COUNT,
  output logic [$clog2(DEPTH):0] BUF_COUNT,
  output logic                   OVERFLOW
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRAIN = 2'd1,
    S_EMIT  = 2'd2
  } state_t;

  logic [31:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [CW-1:0] r_mark_cnt;
  logic [CW-1:0] w_mark_nxt;
  logic [15:0]   r_lost_since;
  state_t        r_state;
  state_t        w_state_nxt;

  logic w_full;
  logic w_accept;
  logic w_drop;
  logic w_pop;
  logic w_emit;

  // Full flag comes from registered occupancy, so a same-cycle pop never frees a slot.
  assign w_full    = (r_count == CW'(DEPTH));
  assign IN_READY  = ~w_full;
  assign w_accept  = IN_WRITE & ~w_full;
  assign w_drop    = IN_WRITE & w_full;
  assign w_emit    = (r_state == S_EMIT) & ENABLE_MARKER & ~OUT_FULL;
  assign w_pop     = (r_count != '0) & ~OUT_FULL & ~w_emit;
  assign BUF_COUNT = r_count;

  // Buffer storage; contents need no reset since occupancy guards every read.
  always_ff @(posedge BUS_CLK) begin
    if (w_accept) begin
      r_mem[r_wr_ptr] <= IN_DATA;
    end
  end

  always_ff @(posedge BUS_CLK) begin
    if (BUS_RST) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_accept) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      if (w_accept && !w_pop) begin
        r_count <= r_count + CW'(1);
      end else if (!w_accept && w_pop) begin
        r_count <= r_count - CW'(1);
      end
    end
  end

  // Downstream write port; data holds between strobes.
  always_ff @(posedge BUS_CLK) begin
    if (BUS_RST) begin
      OUT_WRITE <= 1'b0;
      OUT_DATA  <= '0;
    end else begin
      OUT_WRITE <= w_pop | w_emit;
      if (w_emit) begin
        OUT_DATA <= {MARKER_ID, 12'h000, r_lost_since};
      end else if (w_pop) begin
        OUT_DATA <= r_mem[r_rd_ptr];
      end
    end
  end

  // Status counters; a coincident clear wins over the event.
  always_ff @(posedge BUS_CLK) begin
    if (BUS_RST) begin
      LOST_COUNT <= '0;
      WORD_COUNT <= '0;
      OVERFLOW   <= 1'b0;
    end else if (CLEAR_CNT) begin
      LOST_COUNT <= '0;
      WORD_COUNT <= '0;
      OVERFLOW   <= 1'b0;
    end else begin
      if (w_drop) begin
        OVERFLOW <= 1'b1;
        if (LOST_COUNT != 16'hFFFF) begin
          LOST_COUNT <= LOST_COUNT + 16'd1;
        end
      end
      if (w_pop) begin
        WORD_COUNT <= WORD_COUNT + 32'd1;
      end
    end
  end

  // Words lost since the last marker; held at zero while markers are disabled.
  always_ff @(posedge BUS_CLK) begin
    if (BUS_RST || !ENABLE_MARKER) begin
      r_lost_since <= '0;
    end else if (w_emit) begin
      r_lost_since <= w_drop ? 16'd1 : 16'd0;
    end else if (w_drop && (r_lost_since != 16'hFFFF)) begin
      r_lost_since <= r_lost_since + 16'd1;
    end
  end

  always_ff @(posedge BUS_CLK) begin
    if (BUS_RST) begin
      r_state    <= S_IDLE;
      r_mark_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_mark_cnt <= w_mark_nxt;
    end
  end

  // Marker sequencing: snapshot words ahead of the gap, drain them, then emit.
  always_comb begin
    w_state_nxt = r_state;
    w_mark_nxt  = r_mark_cnt;
    if (!ENABLE_MARKER) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_drop) begin
            w_mark_nxt  = r_count - CW'(w_pop);
            w_state_nxt = (w_mark_nxt == '0) ? S_EMIT : S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (w_pop) begin
            w_mark_nxt = r_mark_cnt - CW'(1);
            if (w_mark_nxt == '0) begin
              w_state_nxt = S_EMIT;
            end
          end
        end
        S_EMIT: begin
          if (w_emit) begin
            w_state_nxt = S_IDLE;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_arb_fifo_bridge.sv
// Bench for arb_fifo_bridge: directed scenarios plus random traffic against a
// queue-based model where a pending marker is an entry placed at the gap.
module tb_arb_fifo_bridge;

  localparam int unsigned DEPTH = 16;
  localparam logic [3:0]  MID   = 4'hE;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_write;
  logic [31:0] in_data;
  logic        out_full;
  logic        en;
  logic        clr;
  logic        in_ready;
  logic        out_write;
  logic [31:0] out_data;
  logic [15:0] lost;
  logic [31:0] wc;
  logic [4:0]  bufc;
  logic        ovf;

  arb_fifo_bridge #(.DEPTH(DEPTH), .MARKER_ID(MID)) dut (
    .BUS_CLK       (clk),
    .BUS_RST       (rst),
    .IN_WRITE      (in_write),
    .IN_DATA       (in_data),
    .IN_READY      (in_ready),
    .OUT_FULL      (out_full),
    .OUT_WRITE     (out_write),
    .OUT_DATA      (out_data),
    .ENABLE_MARKER (en),
    .CLEAR_CNT     (clr),
    .LOST_COUNT    (lost),
    .WORD_COUNT    (wc),
    .BUF_COUNT     (bufc),
    .OVERFLOW      (ovf)
  );

  typedef struct packed {
    logic        mk;
    logic [31:0] d;
  } ent_t;

  ent_t        mq[$];
  int          m_ndata = 0;
  logic [15:0] m_lost_since = '0;
  logic [15:0] m_lc = '0;
  logic [31:0] m_wc = '0;
  logic [31:0] m_od = '0;
  logic        m_ow = 1'b0;
  logic        m_ov = 1'b0;

  logic [31:0] obs[$];
  logic [31:0] exp_q[$];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, expv);
    end
  endtask

  // One clock of the reference model, using the inputs held across the edge.
  task automatic model_step();
    logic ready, acc, drp, pend, emit, pop;
    ent_t e;
    if (rst) begin
      mq.delete();
      m_ndata = 0; m_lost_since = '0; m_lc = '0; m_wc = '0;
      m_od = '0; m_ow = 1'b0; m_ov = 1'b0;
      return;
    end
    ready = (m_ndata != DEPTH);
    acc   = in_write && ready;
    drp   = in_write && !ready;
    if (!en) begin
      for (int i = mq.size() - 1; i >= 0; i--)
        if (mq[i].mk) mq.delete(i);
    end
    pend = 1'b0;
    foreach (mq[i]) if (mq[i].mk) pend = 1'b1;
    emit = en && (mq.size() > 0) && mq[0].mk && !out_full;
    pop  = !out_full && !emit && (m_ndata > 0);
    m_ow = emit || pop;
    if (emit) begin
      m_od = {MID, 12'h000, m_lost_since};
      e = mq.pop_front();
    end else if (pop) begin
      e = mq.pop_front();
      m_od = e.d;
      m_ndata--;
    end
    if (!en) m_lost_since = '0;
    else if (emit) m_lost_since = drp ? 16'd1 : 16'd0;
    else if (drp && m_lost_since != 16'hFFFF) m_lost_since = m_lost_since + 16'd1;
    if (en && drp && !pend) begin
      e.mk = 1'b1; e.d = '0;
      mq.push_back(e);
    end
    if (acc) begin
      e.mk = 1'b0; e.d = in_data;
      mq.push_back(e);
      m_ndata++;
    end
    if (clr) begin
      m_lc = '0; m_wc = '0; m_ov = 1'b0;
    end else begin
      if (drp) begin
        if (m_lc != 16'hFFFF) m_lc = m_lc + 16'd1;
        m_ov = 1'b1;
      end
      if (pop) m_wc = m_wc + 32'd1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    if (out_write) obs.push_back(out_data);
    chk("out_write",  64'(out_write), 64'(m_ow));
    chk("out_data",   64'(out_data),  64'(m_od));
    chk("in_ready",   64'(in_ready),  64'(m_ndata != DEPTH));
    chk("buf_count",  64'(bufc),      64'(m_ndata));
    chk("lost_count", 64'(lost),      64'(m_lc));
    chk("word_count", 64'(wc),        64'(m_wc));
    chk("overflow",   64'(ovf),       64'(m_ov));
  endtask

  task automatic drive(input logic wr, input logic [31:0] d, input logic full);
    in_write = wr;
    in_data  = d;
    out_full = full;
    tick();
  endtask

  task automatic idle(input int n, input logic full);
    for (int i = 0; i < n; i++) drive(1'b0, 32'h0, full);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, 32'h0, 1'b0);
    rst = 1'b0;
    obs.delete();
    exp_q.delete();
  endtask

  task automatic check_stream(input string tag);
    chk({tag, "_len"}, 64'(obs.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs.size(); i++)
      chk(tag, 64'(obs[i]), 64'(exp_q[i]));
  endtask

  initial begin
    int wr_pct;
    rst = 1'b1; in_write = 1'b0; in_data = '0; out_full = 1'b0; en = 1'b1; clr = 1'b0;
    tick();
    rst = 1'b0;
    chk("rst_out_write", 64'(out_write), 64'd0);
    chk("rst_out_data",  64'(out_data),  64'd0);
    chk("rst_buf_count", 64'(bufc),      64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    obs.delete();

    // Streaming 0..99 with no backpressure
    do_reset();
    for (int i = 0; i < 100; i++) begin
      drive(1'b1, 32'(i), 1'b0);
      if (i == 0) chk("lat_edge_n", 64'(out_write), 64'd0);
      if (i == 1) begin
        chk("lat_edge_n1_wr",   64'(out_write), 64'd1);
        chk("lat_edge_n1_data", 64'(out_data),  64'd0);
      end
    end
    idle(4, 1'b0);
    for (int i = 0; i < 100; i++) exp_q.push_back(32'(i));
    check_stream("stream");
    chk("stream_wc",   64'(wc),   64'd100);
    chk("stream_lost", 64'(lost), 64'd0);

    // Backpressure without loss
    do_reset();
    for (int i = 0; i < 16; i++) drive(1'b1, 32'(i), 1'b1);
    chk("bp_in_ready", 64'(in_ready), 64'd0);
    chk("bp_buf_count", 64'(bufc), 64'd16);
    idle(20, 1'b0);
    for (int i = 0; i < 16; i++) exp_q.push_back(32'(i));
    check_stream("bp");
    chk("bp_overflow", 64'(ovf), 64'd0);

    // Loss with marker
    do_reset();
    for (int i = 0; i < 20; i++) drive(1'b1, 32'(i), 1'b1);
    idle(24, 1'b0);
    for (int i = 0; i < 16; i++) exp_q.push_back(32'(i));
    exp_q.push_back(32'hE000_0004);
    check_stream("loss");
    chk("loss_lost", 64'(lost), 64'd4);
    chk("loss_ovf",  64'(ovf),  64'd1);

    // Marker ahead of post-gap words
    do_reset();
    for (int i = 0; i < 18; i++) drive(1'b1, 32'(i), 1'b1);
    idle(3, 1'b0);
    drive(1'b1, 32'h0000_A0A0, 1'b1);
    drive(1'b1, 32'h0000_B0B0, 1'b1);
    idle(24, 1'b0);
    for (int i = 0; i < 16; i++) exp_q.push_back(32'(i));
    exp_q.push_back(32'hE000_0002);
    exp_q.push_back(32'h0000_A0A0);
    exp_q.push_back(32'h0000_B0B0);
    check_stream("gap");

    // Markers disabled
    en = 1'b0;
    do_reset();
    for (int i = 0; i < 20; i++) drive(1'b1, 32'(i), 1'b1);
    idle(24, 1'b0);
    for (int i = 0; i < 16; i++) exp_q.push_back(32'(i));
    check_stream("nomark");
    chk("nomark_lost", 64'(lost), 64'd4);
    en = 1'b1;

    // Reset while draining toward a marker
    do_reset();
    for (int i = 0; i < 20; i++) drive(1'b1, 32'(i), 1'b1);
    idle(8, 1'b0);
    chk("pre_rst_buf", 64'(bufc), 64'd8);
    obs.delete();
    rst = 1'b1;
    drive(1'b0, 32'h0, 1'b1);
    rst = 1'b0;
    chk("mid_rst_write", 64'(out_write), 64'd0);
    chk("mid_rst_buf",   64'(bufc),      64'd0);
    idle(30, 1'b0);
    exp_q.delete();
    check_stream("mid_rst");

    // Clear coincident with a drop
    do_reset();
    for (int i = 0; i < 16; i++) drive(1'b1, 32'(i), 1'b1);
    clr = 1'b1;
    drive(1'b1, 32'd16, 1'b1);
    clr = 1'b0;
    chk("clr_lost", 64'(lost), 64'd0);
    chk("clr_ovf",  64'(ovf),  64'd0);
    drive(1'b1, 32'd17, 1'b1);
    chk("post_clr_lost", 64'(lost), 64'd1);
    chk("post_clr_ovf",  64'(ovf),  64'd1);
    idle(24, 1'b0);

    // Random traffic with bursty backpressure
    do_reset();
    for (int ph = 0; ph < 4; ph++) begin
      wr_pct = (ph == 0) ? 90 : (ph == 1) ? 60 : (ph == 2) ? 40 : 95;
      for (int c = 0; c < 600; c++) begin
        rst      = ($urandom_range(0, 499) == 0);
        in_write = ($urandom_range(0, 99) < wr_pct);
        in_data  = $urandom();
        clr      = ($urandom_range(0, 199) == 0);
        if ($urandom_range(0, 99) < 8) out_full = ~out_full;
        if ($urandom_range(0, 299) == 0) en = ~en;
        tick();
      end
    end
    rst = 1'b0; clr = 1'b0; en = 1'b1;
    idle(40, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
